fir_decimate: RTL and testbench
===============================

// Module: fir_decimate
// PURPOSE
//  Real-valued decimating FIR low-pass filter for the audio path. Sits directly
//  downstream of demodulate_two_inputs and consumes its gain-scaled phase stream
//  from a 32-bit FIFO. Reads DECIMATION samples, computes one filtered output
//  with a NUM_TAPS-cycle serial MAC, then writes that output to the next FIFO.
// PARAMETERS
//  NUM_TAPS    32                        filter length; shift-register depth
//  DECIMATION  8                         input samples consumed per output; 1..NUM_TAPS
//  DATA_WIDTH  32                        sample, coefficient and accumulator width (signed)
//  COEFFS      GLOBALS::AUDIO_LPR_COEFFS signed [DATA_WIDTH-1:0] [NUM_TAPS]; quantized taps
// PORTS
//  clock      in   1           rising-edge clock
//  reset      in   1           synchronous, active-high
//  in_rd_en   out  1           pop input FIFO (first-word-fall-through)
//  in_empty   in   1           input FIFO empty
//  in_dout    in   DATA_WIDTH  signed input sample
//  out_wr_en  out  1           push output FIFO
//  out_full   in   1           output FIFO full
//  out_din    out  DATA_WIDTH  signed filtered, decimated sample
// BEHAVIOUR
//  Interface: one clock; reset is synchronous and active-high.
//  Reset: state=S_LOAD; all x[0..NUM_TAPS-1]=0; load count=0; tap index=0; acc=0.
//    Outputs in_rd_en=0, out_wr_en=0, out_din=0.
//    Reset mid-operation discards the partial block, the history and the accumulator.
//  Storage: x[0] is the oldest sample and x[NUM_TAPS-1] the newest.
//    A shift moves x[k]<=x[k+1] and sets x[NUM_TAPS-1]<=in_dout.
//  S_LOAD:
//    - When !in_empty: in_rd_en=1 (combinational), shift in in_dout, count++.
//    - When in_empty: hold; no shift and no read.
//    - The pop that makes count==DECIMATION sets count=0, acc=0, k=0 and goes to S_MAC.
//    - At most one read per cycle.
//  S_MAC (exactly NUM_TAPS cycles, k=0..NUM_TAPS-1):
//    - acc += DEQUANTIZE_I(COEFFS[NUM_TAPS-1-k] * x[k]).
//    - The product is truncated to DATA_WIDTH bits before GLOBALS::DEQUANTIZE_I.
//    - The sum wraps modulo 2^DATA_WIDTH; no saturation.
//    - in_rd_en=0 throughout; inputs may back up in the FIFO.
//    - Go to S_WRITE after k=NUM_TAPS-1.
//  S_WRITE:
//    - When !out_full: out_wr_en=1, out_din=acc (both combinational), go to S_LOAD.
//    - When out_full: hold acc and wait; out_wr_en=0. No input read in this state.
//  Latency: the DECIMATION-th pop occurs on cycle T. With out_full low, out_wr_en=1
//    on cycle T+NUM_TAPS+1. Steady-state throughput is one output per
//    DECIMATION+NUM_TAPS+1 cycles when the input FIFO never empties.
//  Startup: the history is zero, so early outputs see zero-filled taps. There is
//    no priming phase; the first output follows the first DECIMATION pops.
//  Bit-exact with the C fir(): y = sum_j DEQUANTIZE(coeff[TAPS-1-j] * x[j]).
// TESTING
//  Common setup: COEFFS all 1024 (1.0 at BITS=10), default taps and decimation.
//  1 Impulse: in = 1024, then 39 zeros -> 5 outputs: 1024,1024,1024,1024,0.
//  2 DC: 64 samples of 100 -> outputs 800,1600,2400,3200,3200,...
//  3 Backpressure: hold out_full=1 for 50 cycles during S_WRITE.
//      -> out_wr_en stays 0, in_rd_en stays 0, out_din is unchanged on release,
//         no sample is lost.
//  4 Starved input: in_empty toggles randomly.
//      -> outputs match the golden C fir() model and the output count equals
//         pops/8 exactly.
//  5 Reset mid-S_MAC: assert reset, then replay test 1 -> identical output
//      sequence; no stale history.
//  6 Sign and wrap: in = -2^20 with COEFFS[7] = -1024 -> output +2^20;
//      also check negative DEQUANTIZE_I rounding against the C model.

Source files
------------

// File: rtl/fir_decimate.sv
// Decimating real FIR low-pass for the audio path.
// Loads DECIMATION samples into a NUM_TAPS-deep history, runs one serial
// multiply-accumulate pass over all taps, then pushes a single output.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_LOAD  | pop input FIFO into the history until DECIMATION samples
//   S_MAC   | one tap per cycle, acc += dequant(coeff[N-1-k] * x[k])
//   S_WRITE | present acc to the output FIFO, wait while it is full
module fir_decimate #(
   parameter int NUM_TAPS   = 32,
   parameter int DECIMATION = 8,
   parameter int DATA_WIDTH = 32,
   parameter int BITS       = 10,
   // tap i lives at COEFFS[i*DATA_WIDTH +: DATA_WIDTH]; default is 1.0 on every tap
   parameter logic [NUM_TAPS*DATA_WIDTH-1:0] COEFFS = {NUM_TAPS{DATA_WIDTH'(1024)}}
) (
   input  logic                  clock,
   input  logic                  reset,
   output logic                  in_rd_en,
   input  logic                  in_empty,
   input  logic [DATA_WIDTH-1:0] in_dout,
   output logic                  out_wr_en,
   input  logic                  out_full,
   output logic [DATA_WIDTH-1:0] out_din
);

   localparam int CW = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
   localparam int TW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_MAC   = 2'd1,
      S_WRITE = 2'd2
   } state_t;

   state_t                       state_q, state_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic [TW-1:0]                tap_q, tap_d;
   logic signed [DATA_WIDTH-1:0] acc_q, acc_d;
   logic signed [DATA_WIDTH-1:0] x_q [NUM_TAPS];
   logic signed [DATA_WIDTH-1:0] x_d [NUM_TAPS];

   logic signed [DATA_WIDTH-1:0] coef;
   logic signed [DATA_WIDTH-1:0] x_sel;
   logic signed [DATA_WIDTH-1:0] prod;
   logic signed [DATA_WIDTH-1:0] bias;
   logic signed [DATA_WIDTH-1:0] deq;

   // Current tap product, truncated to DATA_WIDTH and divided by 2^BITS
   // rounding toward zero (bias negatives before the arithmetic shift).
   always_comb begin
      coef  = COEFFS[(NUM_TAPS - 1 - int'(tap_q)) * DATA_WIDTH +: DATA_WIDTH];
      x_sel = x_q[tap_q];
      prod  = coef * x_sel;
      bias  = prod[DATA_WIDTH-1] ? DATA_WIDTH'((1 << BITS) - 1) : '0;
      deq   = (prod + bias) >>> BITS;
   end

   // Next-state, datapath updates and FIFO handshakes.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      tap_d     = tap_q;
      acc_d     = acc_q;
      x_d       = x_q;
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
      out_din   = '0;
      case (state_q)
         S_LOAD: begin
            if (!in_empty) begin
               in_rd_en = 1'b1;
               for (int k = 0; k < NUM_TAPS - 1; k++) begin
                  x_d[k] = x_q[k+1];
               end
               x_d[NUM_TAPS-1] = $signed(in_dout);
               if (cnt_q == CW'(DECIMATION - 1)) begin
                  cnt_d   = '0;
                  acc_d   = '0;
                  tap_d   = '0;
                  state_d = S_MAC;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_MAC: begin
            acc_d = acc_q + deq;
            if (tap_q == TW'(NUM_TAPS - 1)) begin
               state_d = S_WRITE;
            end else begin
               tap_d = tap_q + 1'b1;
            end
         end
         S_WRITE: begin
            if (!out_full) begin
               out_wr_en = 1'b1;
               out_din   = acc_q;
               state_d   = S_LOAD;
            end
         end
         default: state_d = S_LOAD;
      endcase
      // handshakes stay quiet while reset is held, whatever the flops hold
      if (reset) begin
         in_rd_en  = 1'b0;
         out_wr_en = 1'b0;
         out_din   = '0;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_LOAD;
         cnt_q   <= '0;
         tap_q   <= '0;
         acc_q   <= '0;
         for (int k = 0; k < NUM_TAPS; k++) begin
            x_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tap_q   <= tap_d;
         acc_q   <= acc_d;
         x_q     <= x_d;
      end
   end

endmodule

// File: tb/tb_fir_decimate.sv
// Bench for fir_decimate: two instances share one stimulus stream, one with
// unity taps and one with a sign-flipped tap 7 and a non-power-of-two tap 6.
module tb_fir_decimate;

   localparam int NT  = 32;
   localparam int DEC = 8;
   localparam int DW  = 32;

   function automatic logic [NT*DW-1:0] coeff_vec(input bit alt);
      logic [NT*DW-1:0] v;
      int c;
      for (int i = 0; i < NT; i++) begin
         c = 1024;
         if (alt && i == 7) c = -1024;
         if (alt && i == 6) c = 1000;
         v[i*DW +: DW] = DW'(c);
      end
      return v;
   endfunction

   localparam logic [NT*DW-1:0] CO_A = coeff_vec(1'b0);
   localparam logic [NT*DW-1:0] CO_B = coeff_vec(1'b1);

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_empty = 1'b1;
   logic [DW-1:0] in_dout = '0;
   logic          out_full = 1'b0;
   logic          rd_a, wr_a, rd_b, wr_b;
   logic [DW-1:0] dout_a, dout_b;

   always #5 clock = ~clock;

   fir_decimate #(.NUM_TAPS(NT), .DECIMATION(DEC), .DATA_WIDTH(DW), .BITS(10), .COEFFS(CO_A)) dut_a (
      .clock(clock), .reset(reset), .in_rd_en(rd_a), .in_empty(in_empty), .in_dout(in_dout),
      .out_wr_en(wr_a), .out_full(out_full), .out_din(dout_a));

   fir_decimate #(.NUM_TAPS(NT), .DECIMATION(DEC), .DATA_WIDTH(DW), .BITS(10), .COEFFS(CO_B)) dut_b (
      .clock(clock), .reset(reset), .in_rd_en(rd_b), .in_empty(in_empty), .in_dout(in_dout),
      .out_wr_en(wr_b), .out_full(out_full), .out_din(dout_b));

   int nchk = 0;
   int nerr = 0;

   // model state
   int     coef_a [NT];
   int     coef_b [NT];
   int     hist [$];
   int     exp_a [$];
   int     exp_b [$];
   int     got_a [$];
   int     got_b [$];
   int     want [$];
   int     in_q [$];
   int     npop = 0;
   int     nwr = 0;
   bit     pend = 0;
   bit     popped = 0;
   longint cycle = 0;
   longint due = 0;

   // stimulus knobs
   int starve_pct = 0;
   int full_pct = 0;
   bit full_force = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // y = sum_j (coeff[NT-1-j] * x[j]) / 1024, x[0] oldest, 32-bit wrapping ints
   function automatic int model_out(input int co [NT]);
      int y, idx, xv, p;
      y = 0;
      for (int j = 0; j < NT; j++) begin
         idx = hist.size() - NT + j;
         xv  = (idx >= 0) ? hist[idx] : 0;
         p   = co[NT-1-j] * xv;
         y   = y + p / 1024;
      end
      return y;
   endfunction

   // input/output FIFO emulation
   always @(negedge clock) begin
      if (popped) begin
         if (in_q.size() > 0) in_q.delete(0);
         popped = 0;
      end
      in_empty = (in_q.size() == 0) ||
                 ((starve_pct > 0) && ($urandom_range(99) < starve_pct));
      in_dout  = (in_q.size() > 0) ? DW'(in_q[0]) : DW'($urandom());
      out_full = full_force || ((full_pct > 0) && ($urandom_range(99) < full_pct));
   end

   // compare process: checks handshakes and data every cycle against the model
   always @(negedge clock) begin
      bit exp_wr;
      #2;
      cycle++;
      if (reset) begin
         chk("reset_rd_en", rd_a, 0);
         chk("reset_wr_en", wr_a, 0);
         chk("reset_dout", dout_a, 0);
         hist.delete();
         exp_a.delete();
         exp_b.delete();
         pend   = 0;
         popped = 0;
         npop   = 0;
         nwr    = 0;
      end else begin
         chk("pair_rd_en", rd_b, rd_a);
         chk("pair_wr_en", wr_b, wr_a);
         if (!pend) begin
            chk("load_rd_en", rd_a, !in_empty);
            chk("load_wr_en", wr_a, 0);
            if (rd_a && !in_empty) begin
               hist.push_back(int'($signed(in_dout)));
               popped = 1;
               npop++;
               if (npop % DEC == 0) begin
                  pend = 1;
                  due  = cycle + NT + 1;
                  exp_a.push_back(model_out(coef_a));
                  exp_b.push_back(model_out(coef_b));
               end
            end
         end else begin
            exp_wr = (cycle >= due) && !out_full;
            chk("busy_rd_en", rd_a, 0);
            chk("wr_en_timing", wr_a, exp_wr);
            if (exp_wr && wr_a) begin
               chk("dout_a", $signed(dout_a), exp_a[0]);
               chk("dout_b", $signed(dout_b), exp_b[0]);
               got_a.push_back(int'($signed(dout_a)));
               got_b.push_back(int'($signed(dout_b)));
               exp_a.delete(0);
               exp_b.delete(0);
               nwr++;
               pend = 0;
            end
         end
      end
   end

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (!(in_q.size() == 0 && !pend && !popped) && n < budget) begin
         @(negedge clock);
         #3;
         n++;
      end
      chk({name, "_drained"}, (in_q.size() == 0 && !pend && !popped), 1);
   endtask

   task automatic check_seq(input string name, input bit use_b);
      chk({name, "_count"}, use_b ? got_b.size() : got_a.size(), want.size());
      for (int i = 0; i < want.size(); i++) begin
         if (i < (use_b ? got_b.size() : got_a.size()))
            chk({name, "_value"}, use_b ? got_b[i] : got_a[i], want[i]);
      end
   endtask

   task automatic push_impulse(input int v, input int pos, input int len);
      for (int i = 0; i < len; i++) in_q.push_back((i == pos) ? v : 0);
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clock);
      in_q.delete();
      reset = 1'b1;
      repeat (cycles) @(negedge clock);
      reset = 1'b0;
   endtask

   initial begin
      int n;
      for (int i = 0; i < NT; i++) begin
         coef_a[i] = 1024;
         coef_b[i] = (i == 7) ? -1024 : ((i == 6) ? 1000 : 1024);
      end
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // impulse through unity taps
      got_a.delete(); got_b.delete();
      push_impulse(1024, 0, 40);
      drain("impulse", 2000);
      want = '{1024, 1024, 1024, 1024, 0};
      check_seq("impulse", 1'b0);

      // DC ramp-up from zero history
      got_a.delete(); got_b.delete();
      for (int i = 0; i < 64; i++) in_q.push_back(100);
      drain("dc", 3000);
      want = '{800, 1600, 2400, 3200, 3200, 3200, 3200, 3200};
      check_seq("dc", 1'b0);

      // backpressure: hold the output FIFO full well past the write point
      full_force = 1;
      for (int i = 0; i < 16; i++) in_q.push_back(int'($urandom_range(4000)) - 2000);
      n = 0;
      while (!(pend && cycle >= due) && n < 500) begin
         @(negedge clock); #3; n++;
      end
      chk("bp_reached_write", (pend && cycle >= due), 1);
      repeat (50) @(negedge clock);
      full_force = 0;
      drain("bp", 2000);
      chk("bp_out_count", nwr, npop / DEC);

      // starved input and random output backpressure, full-range data
      starve_pct = 40;
      full_pct   = 20;
      for (int i = 0; i < 200; i++)
         in_q.push_back(i[0] ? int'($urandom()) : int'($urandom_range(4000)) - 2000);
      drain("starve", 20000);
      chk("starve_out_count", nwr, npop / DEC);
      starve_pct = 0;
      full_pct   = 0;

      // reset in the middle of a MAC pass, then replay the impulse
      for (int i = 0; i < 16; i++) in_q.push_back(int'($urandom()));
      n = 0;
      while (!(pend && (due - cycle) <= 16) && n < 500) begin
         @(negedge clock); #3; n++;
      end
      chk("mid_mac_reached", (pend && (due - cycle) <= 16), 1);
      do_reset(2);
      got_a.delete(); got_b.delete();
      push_impulse(1024, 0, 40);
      drain("replay", 2000);
      want = '{1024, 1024, 1024, 1024, 0};
      check_seq("replay", 1'b0);

      // sign: -2^20 meets tap 7 = -1024 first
      got_a.delete(); got_b.delete();
      push_impulse(-(1 << 20), 0, 40);
      drain("sign", 2000);
      want = '{(1 << 20), -(1 << 20), -(1 << 20), -(1 << 20), 0};
      check_seq("sign_b", 1'b1);
      want = '{-(1 << 20), -(1 << 20), -(1 << 20), -(1 << 20), 0};
      check_seq("sign_a", 1'b0);

      // negative rounding toward zero: -1 hits tap 6 = 1000 -> -1000/1024 = 0
      got_a.delete(); got_b.delete();
      push_impulse(-1, 1, 40);
      drain("round", 2000);
      want = '{0, -1, -1, -1, 0};
      check_seq("round_b", 1'b1);
      want = '{-1, -1, -1, -1, 0};
      check_seq("round_a", 1'b0);

      repeat (4) @(negedge clock);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
